channel_sched: RTL

CHANNEL_SCHED -- requirements
Module: channel_sched

---
 rtl/audio_pkg.sv | 18 +
 rtl/channel_sched.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, mode encodings and scheduler state encoding.
package audio_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [1:0] FILTER_SEL = 2'b01;
  localparam logic [1:0] BYPASS_SEL = 2'b10;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRunL  = 3'd1,
    StWaitL = 3'd2,
    StRunR  = 3'd3,
    StWaitR = 3'd4,
    StEmit  = 3'd5
  } state_e;

endpackage

// File: rtl/channel_sched.sv
// Stereo channel scheduler: shares one external FIR core between left and right ADC samples
// and drives registered DAC outputs in filter, bypass or mute mode.
module channel_sched
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = audio_pkg::DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] adc_left_i,
  input  logic [DATA_WIDTH-1:0] adc_right_i,
  input  logic [1:0]            sel_i,
  output logic                  fir_start_o,
  output logic [DATA_WIDTH-1:0] fir_data_o,
  input  logic                  fir_done_i,
  input  logic [DATA_WIDTH-1:0] fir_result_i,
  output logic [DATA_WIDTH-1:0] dac_left_o,
  output logic [DATA_WIDTH-1:0] dac_right_o,
  output logic                  dac_valid_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] left_q, right_q, res_l_q, res_r_q;
  logic [1:0]            mode_q;
  logic [CntW-1:0]       cnt_q;
  logic                  fir_start_q, dac_valid_q, overrun_q, timeout_q;
  logic [DATA_WIDTH-1:0] fir_data_q, dac_l_q, dac_r_q;
  logic                  wait_over;

  always_comb begin
    wait_over = fir_done_i || (cnt_q == CntLast);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      left_q      <= '0;
      right_q     <= '0;
      res_l_q     <= '0;
      res_r_q     <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      fir_start_q <= 1'b0;
      fir_data_q  <= '0;
      dac_l_q     <= '0;
      dac_r_q     <= '0;
      dac_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      dac_valid_q <= 1'b0;
      // Any strobe outside IDLE (EMIT included) is dropped and flagged.
      if (sample_valid_i && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (sample_valid_i) begin
            left_q  <= adc_left_i;
            right_q <= adc_right_i;
            mode_q  <= sel_i;
            if (sel_i == FILTER_SEL) begin
              fir_start_q <= 1'b1;
              fir_data_q  <= adc_left_i;
              state_q     <= StRunL;
            end else begin
              state_q <= StEmit;
            end
          end
        end
        StRunL: begin
          fir_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StWaitL;
        end
        StWaitL: begin
          if (wait_over) begin
            // A done coinciding with the last count still wins over the timeout.
            res_l_q     <= fir_done_i ? fir_result_i : left_q;
            timeout_q   <= timeout_q | ~fir_done_i;
            fir_start_q <= 1'b1;
            fir_data_q  <= right_q;
            state_q     <= StRunR;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRunR: begin
          fir_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StWaitR;
        end
        StWaitR: begin
          if (wait_over) begin
            res_r_q   <= fir_done_i ? fir_result_i : right_q;
            timeout_q <= timeout_q | ~fir_done_i;
            state_q   <= StEmit;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StEmit: begin
          if (mode_q == FILTER_SEL) begin
            dac_l_q <= res_l_q;
            dac_r_q <= res_r_q;
          end else if (mode_q == BYPASS_SEL) begin
            dac_l_q <= left_q;
            dac_r_q <= right_q;
          end else begin
            dac_l_q <= '0;
            dac_r_q <= '0;
          end
          dac_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    fir_start_o = fir_start_q;
    fir_data_o  = fir_data_q;
    dac_left_o  = dac_l_q;
    dac_right_o = dac_r_q;
    dac_valid_o = dac_valid_q;
    busy_o      = (state_q != StIdle);
    overrun_o   = overrun_q;
    timeout_o   = timeout_q;
  end

endmodule
